// File: rtl/key_led_pkg.sv
// Shared constants for the key-to-LED driver: per-channel mode encoding.
package key_led_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
  localparam logic [MODE_W-1:0] MODE_DIM   = 2'd3;

endpackage

// File: rtl/key_led_drv_if.sv
// Key/LED signal bundle between the debounce stage, this driver and the LED pins.
interface key_led_drv_if #(
  parameter int LED_WIDTH = 8
);

  logic [LED_WIDTH-1:0]   btn_deb;
  logic [LED_WIDTH-1:0]   led;
  logic [2*LED_WIDTH-1:0] led_mode;
  logic [LED_WIDTH-1:0]   press_pulse;

  modport master (
    output btn_deb,
    input  led,
    input  led_mode,
    input  press_pulse
  );

  modport slave (
    input  btn_deb,
    output led,
    output led_mode,
    output press_pulse
  );

endinterface

// File: rtl/led_timebase.sv
// Free-running blink and PWM timebases shared by every LED channel so that
// all blinking LEDs stay in phase.
module led_timebase #(
  parameter logic [23:0] BLINK_HALF = 24'd6750000,
  parameter logic [7:0]  DIM_DUTY   = 8'd64
) (
  input  logic clk,
  input  logic rst,
  output logic blink_ph,
  output logic dim_on
);

  localparam logic [23:0] BLINK_LAST = BLINK_HALF - 24'd1;

  logic [23:0] blink_cnt;
  logic [7:0]  pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 24'd1;
      end
    end
  end

  // DIM_DUTY of 0 never lights; 8-bit compare keeps the duty in 1/256 steps
  assign dim_on = (pwm_cnt < DIM_DUTY);

endmodule

// File: rtl/key_led_drv.sv
// Steps each LED through OFF -> ON -> BLINK -> DIM -> OFF on every key press;
// all outputs registered.
module key_led_drv
  import key_led_pkg::*;
#(
  parameter int          LED_WIDTH   = 8,
  parameter logic [23:0] BLINK_HALF  = 24'd6750000,
  parameter logic [7:0]  DIM_DUTY    = 8'd64,
  parameter logic        BTN_ACT_LOW = 1'b1,
  parameter logic        LED_ACT_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  key_led_drv_if.slave  bus
);

  logic [LED_WIDTH-1:0]        pressed;
  logic [LED_WIDTH-1:0]        pressed_q;
  logic [LED_WIDTH-1:0]        btn_prev;
  logic [LED_WIDTH-1:0]        press;
  logic [LED_WIDTH-1:0]        press_pulse_q;
  logic [LED_WIDTH-1:0]        lit;
  logic [LED_WIDTH-1:0]        led_q;
  logic [MODE_W*LED_WIDTH-1:0] mode_q;
  logic                        blink_ph;
  logic                        dim_on;

  led_timebase #(
    .BLINK_HALF (BLINK_HALF),
    .DIM_DUTY   (DIM_DUTY)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .blink_ph (blink_ph),
    .dim_on   (dim_on)
  );

  assign pressed = bus.btn_deb ^ {LED_WIDTH{BTN_ACT_LOW}};
  // pressed_q is the sampled level; btn_prev lags it by one cycle
  assign press   = pressed_q & ~btn_prev;

  always_comb begin
    lit = '0;
    for (int i = 0; i < LED_WIDTH; i++) begin
      case (mode_q[MODE_W*i +: MODE_W])
        MODE_ON:    lit[i] = 1'b1;
        MODE_BLINK: lit[i] = blink_ph;
        MODE_DIM:   lit[i] = dim_on;
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q     <= '0;
      btn_prev      <= '0;
      press_pulse_q <= '0;
      mode_q        <= '0;
      led_q         <= {LED_WIDTH{LED_ACT_LOW}};
    end else begin
      pressed_q     <= pressed;
      btn_prev      <= pressed_q;
      press_pulse_q <= press;
      led_q         <= lit ^ {LED_WIDTH{LED_ACT_LOW}};
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (press[i]) begin
          mode_q[MODE_W*i +: MODE_W] <= mode_q[MODE_W*i +: MODE_W] + 2'd1;
        end
      end
    end
  end

  assign bus.led         = led_q;
  assign bus.led_mode    = mode_q;
  assign bus.press_pulse = press_pulse_q;

endmodule

// File: tb/tb_key_led_drv.sv
// Self-checking bench for key_led_drv: directed scenarios plus random key
// activity, compared each cycle against a cycle-count based reference model.
module tb_key_led_drv;

  localparam int W  = 8;
  localparam int BH = 10;
  localparam int DD = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_led_drv_if #(.LED_WIDTH(W)) bus ();

  key_led_drv #(
    .LED_WIDTH   (W),
    .BLINK_HALF  (24'd10),
    .DIM_DUTY    (8'd64),
    .BTN_ACT_LOW (1'b1),
    .LED_ACT_LOW (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: k = edges since last reset edge, so the blink phase is
  // (k / BH) odd and the PWM count is k mod 256.  A key level seen at edge N
  // becomes a press at edge N+1; the LED follows the mode one edge later.
  int              k = 0;
  logic [1:0]      mode_m [W];
  logic [W-1:0]    seen_now  = '0;
  logic [W-1:0]    seen_prev = '0;
  logic [W-1:0]    exp_led   = '0;
  logic [W-1:0]    exp_pulse = '0;
  logic [W-1:0]    pr;

  initial for (int i = 0; i < W; i++) mode_m[i] = 2'd0;

  function automatic logic lit_of(input logic [1:0] m, input int kk);
    case (m)
      2'd1:    return 1'b1;
      2'd2:    return ((kk / BH) % 2) == 1;
      2'd3:    return (kk % 256) < DD;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2*W-1:0] exp_mode();
    logic [2*W-1:0] v;
    for (int i = 0; i < W; i++) v[2*i +: 2] = mode_m[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      for (int i = 0; i < W; i++) mode_m[i] = 2'd0;
      exp_led   = '0;
      exp_pulse = '0;
      seen_now  = '0;
      seen_prev = '0;
    end else begin
      pr = seen_now & ~seen_prev;
      for (int i = 0; i < W; i++) begin
        exp_led[i] = lit_of(mode_m[i], k);
        if (pr[i]) mode_m[i] = mode_m[i] + 2'd1;
      end
      exp_pulse = pr;
      seen_prev = seen_now;
      seen_now  = ~bus.btn_deb;
      k++;
    end
  end

  always @(negedge clk) begin
    check("led", 32'(bus.led), 32'(exp_led));
    check("led_mode", 32'(bus.led_mode), 32'(exp_mode()));
    check("press_pulse", 32'(bus.press_pulse), 32'(exp_pulse));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n, input int ch, output int pulses, output int lit_cnt);
    pulses  = 0;
    lit_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      pulses  += int'(bus.press_pulse[ch]);
      lit_cnt += int'(bus.led[ch]);
    end
  endtask

  task automatic pulse_key(input int ch);
    bus.btn_deb[ch] = 1'b0;
    cyc(2);
    bus.btn_deb[ch] = 1'b1;
    cyc(3);
  endtask

  int p, l, guard, same;

  initial begin
    bus.btn_deb = 8'hFF;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    run_count(100, 0, p, l);
    check("idle_led0", 32'(l), 32'd0);
    check("idle_mode", 32'(bus.led_mode), 32'h0000);

    // key 0 pressed and held: exactly one advance
    bus.btn_deb = 8'hFE;
    cyc(2);
    check("hold_first_pulse", 32'(bus.press_pulse), 32'h01);
    check("hold_first_mode", 32'(bus.led_mode[1:0]), 32'd1);
    run_count(48, 0, p, l);
    check("hold_pulses", 32'(p), 32'd0);
    check("hold_mode", 32'(bus.led_mode[1:0]), 32'd1);
    bus.btn_deb = 8'hFF;
    cyc(5);

    // return channel 0 to OFF, then walk the full cycle
    for (int i = 0; i < 3; i++) pulse_key(0);
    check("back_to_off", 32'(bus.led_mode[1:0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pulse_key(0);
      check("cycle_mode", 32'(bus.led_mode[1:0]), 32'((i + 1) % 4));
      if (i == 1) begin
        run_count(40, 0, p, l);
        check("blink_lit_40", 32'(l), 32'd20);
      end
      if (i == 2) begin
        run_count(256, 0, p, l);
        check("dim_lit_256", 32'(l), 32'd64);
      end
    end

    // keys 3 and 5 together
    bus.btn_deb = 8'hD7;
    cyc(2);
    check("dual_pulse", 32'(bus.press_pulse), 32'h28);
    cyc(1);
    check("dual_pulse_gone", 32'(bus.press_pulse), 32'h00);
    check("dual_mode3", 32'(bus.led_mode[7:6]), 32'd1);
    check("dual_mode5", 32'(bus.led_mode[11:10]), 32'd1);
    bus.btn_deb = 8'hFF;
    cyc(3);

    // channels 1 and 2 enter BLINK 7 cycles apart
    pulse_key(1);
    pulse_key(2);
    bus.btn_deb[1] = 1'b0;
    cyc(2);
    bus.btn_deb[1] = 1'b1;
    cyc(5);
    bus.btn_deb[2] = 1'b0;
    cyc(2);
    bus.btn_deb[2] = 1'b1;
    cyc(3);
    check("blink_mode1", 32'(bus.led_mode[3:2]), 32'd2);
    check("blink_mode2", 32'(bus.led_mode[5:4]), 32'd2);
    same = 0;
    repeat (60) begin
      @(negedge clk);
      same += int'(bus.led[1] == bus.led[2]);
    end
    check("blink_in_phase", 32'(same), 32'd60);

    // channel 0 into DIM with key held, reset when blink_cnt is 6
    pulse_key(0);
    pulse_key(0);
    bus.btn_deb[0] = 1'b0;
    cyc(3);
    check("pre_rst_dim", 32'(bus.led_mode[1:0]), 32'd3);
    guard = 0;
    while ((k % BH) != 6 && guard < 2 * BH) begin
      cyc(1);
      guard++;
    end
    check("rst_align_bound", 32'(k % BH), 32'd6);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mode", 32'(bus.led_mode), 32'h0000);
    check("rst_led", 32'(bus.led), 32'h00);
    check("rst_blink_cnt", 32'(dut.u_timebase.blink_cnt), 32'd0);
    check("rst_pwm_cnt", 32'(dut.u_timebase.pwm_cnt), 32'd0);
    run_count(3, 0, p, l);
    check("held_through_rst", 32'(p), 32'd1);
    bus.btn_deb[0] = 1'b1;
    cyc(4);

    // random key activity with occasional resets
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(7, 0) == 0) begin
        bus.btn_deb[$urandom_range(W - 1, 0)] ^= 1'b1;
      end
      rst = ($urandom_range(499, 0) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
